// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues host I2C commands, launches them on an i2c_master
// addr/data_in/rw/enable interface and returns read bytes via a response FIFO.
// Optional watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_cmd_sequencer #(
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned RSP_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_rw,
    input  logic [6:0]                 cmd_addr,
    input  logic [7:0]                 cmd_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [7:0]                 rsp_data,
    output logic                       rsp_err,
    output logic [6:0]                 m_addr,
    output logic [7:0]                 m_data_in,
    output logic                       m_rw,
    output logic                       m_enable,
    input  logic                       m_ready,
    input  logic [7:0]                 m_data_out,
    output logic                       busy,
    output logic [$clog2(CMD_DEPTH):0] cmd_count
);

    localparam int unsigned CMD_AW = $clog2(CMD_DEPTH);
    localparam int unsigned CMD_PW = CMD_AW + 1;
    localparam int unsigned RSP_AW = $clog2(RSP_DEPTH);
    localparam int unsigned RSP_PW = RSP_AW + 1;

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        PUSH_RSP  = 3'd4
    } state_t;

    // Elaboration-time parameter sanity checks
    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_cmd_depth
        $error("CMD_DEPTH must be a power of 2 and at least 2");
    end
    if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_rsp_depth
        $error("RSP_DEPTH must be a power of 2 and at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    cmd_t              cmd_mem [CMD_DEPTH];
    logic [CMD_PW-1:0] cmd_wr_ptr;
    logic [CMD_PW-1:0] cmd_rd_ptr;
    cmd_t              cmd_head_c;
    logic              cmd_empty_c;
    logic              cmd_push_c;

    logic [7:0]        rsp_mem [RSP_DEPTH];
    logic [RSP_PW-1:0] rsp_wr_ptr;
    logic [RSP_PW-1:0] rsp_rd_ptr;
    logic [RSP_PW-1:0] rsp_cnt_c;
    logic              rsp_free_c;
    logic              rsp_push_c;
    logic              rsp_pop_c;
    logic [7:0]        rsp_wdata_c;
    logic              rsv_q;

    state_t            state_q;
    state_t            state_d;
    logic              launch_c;
    logic              timeout_c;

    assign cmd_count   = cmd_wr_ptr - cmd_rd_ptr;
    assign cmd_empty_c = (cmd_wr_ptr == cmd_rd_ptr);
    assign cmd_ready   = (cmd_count != CMD_PW'(CMD_DEPTH));
    assign cmd_push_c  = cmd_valid & cmd_ready;
    assign cmd_head_c  = cmd_mem[cmd_rd_ptr[CMD_AW-1:0]];

    assign rsp_cnt_c   = rsp_wr_ptr - rsp_rd_ptr;
    assign rsp_valid   = (rsp_wr_ptr != rsp_rd_ptr);
    assign rsp_pop_c   = rsp_valid & rsp_ready;
    assign rsp_data    = rsp_mem[rsp_rd_ptr[RSP_AW-1:0]];
    assign rsp_free_c  = (rsp_cnt_c + RSP_PW'(rsv_q)) < RSP_PW'(RSP_DEPTH);

    assign busy        = (state_q != IDLE) | ~cmd_empty_c;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            to_err_q;
    logic            rsp_err_mem [RSP_DEPTH];

    assign timeout_c   = ((state_q == WAIT_BUSY) || (state_q == WAIT_DONE)) &&
                         (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign rsp_wdata_c = to_err_q ? 8'hFF : m_data_out;
    assign rsp_err     = rsp_err_mem[rsp_rd_ptr[RSP_AW-1:0]];

    // Watchdog counter and sticky error for the in-flight transfer
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else if (state_q == LAUNCH) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else if ((state_q == WAIT_BUSY) || (state_q == WAIT_DONE)) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
            if (timeout_c && !((state_q == WAIT_DONE) && m_ready)) begin
                to_err_q <= 1'b1;
            end
        end
    end

    // Error flag storage alongside the response data
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                rsp_err_mem[i] <= 1'b0;
            end
        end else if (rsp_push_c) begin
            rsp_err_mem[rsp_wr_ptr[RSP_AW-1:0]] <= to_err_q;
        end
    end
`else
    assign timeout_c   = 1'b0;
    assign rsp_wdata_c = m_data_out;
    assign rsp_err     = 1'b0;
`endif

    // Command FIFO storage
    always_ff @(posedge clk) begin
        if (cmd_push_c) begin
            cmd_mem[cmd_wr_ptr[CMD_AW-1:0]] <= '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};
        end
    end

    // Command FIFO pointers
    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
        end else begin
            if (cmd_push_c) cmd_wr_ptr <= cmd_wr_ptr + CMD_PW'(1);
            if (launch_c)   cmd_rd_ptr <= cmd_rd_ptr + CMD_PW'(1);
        end
    end

    // Response FIFO storage, pointers and the single read-slot reservation
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                rsp_mem[i] <= '0;
            end
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
            rsv_q      <= 1'b0;
        end else begin
            if (rsp_push_c) begin
                rsp_mem[rsp_wr_ptr[RSP_AW-1:0]] <= rsp_wdata_c;
                rsp_wr_ptr <= rsp_wr_ptr + RSP_PW'(1);
            end
            if (rsp_pop_c) rsp_rd_ptr <= rsp_rd_ptr + RSP_PW'(1);
            if (launch_c && cmd_head_c.rw) rsv_q <= 1'b1;
            else if (rsp_push_c)           rsv_q <= 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next-state and strobes
    always_comb begin
        state_d    = state_q;
        launch_c   = 1'b0;
        rsp_push_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!cmd_empty_c && m_ready && (!cmd_head_c.rw || rsp_free_c)) begin
                    launch_c = 1'b1;
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (timeout_c)     state_d = m_rw ? PUSH_RSP : IDLE;
                else if (!m_ready) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (m_ready || timeout_c) state_d = m_rw ? PUSH_RSP : IDLE;
            end
            PUSH_RSP: begin
                rsp_push_c = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Master interface registers; held stable between launches
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_enable  <= 1'b0;
            m_addr    <= '0;
            m_data_in <= '0;
            m_rw      <= 1'b0;
        end else begin
            m_enable <= launch_c;
            if (launch_c) begin
                m_addr    <= cmd_head_c.addr;
                m_data_in <= cmd_head_c.wdata;
                m_rw      <= cmd_head_c.rw;
            end
        end
    end

endmodule
